// File: rtl/lauflicht_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : lauflicht_ctrl_if
//  Description : Control/status bundle of the running-light controller.
//                Controls : en (run/freeze), mode (left/right/ping-pong/hold),
//                           speed (prescaler shift).
//                Status   : led (one-hot, polarity applied), pos, tick.
//                master = whoever drives the controls, slave = the controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lauflicht_ctrl_if #(
    parameter int N_LED = 8,
    parameter int POS_W = (N_LED > 1) ? $clog2(N_LED) : 1
);
    logic             en;
    logic [1:0]       mode;
    logic [1:0]       speed;
    logic [N_LED-1:0] led;
    logic [POS_W-1:0] pos;
    logic             tick;

    modport master (output en, mode, speed, input  led, pos, tick);
    modport slave  (input  en, mode, speed, output led, pos, tick);
endinterface
`default_nettype wire

// File: rtl/lauflicht_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lauflicht_ctrl
//  Description : Running-light controller. A runtime-selectable prescaler
//                (PRESCALE >> speed cycles per step) advances a lit position
//                in left, right, ping-pong or hold mode.
//                Ports: clk   - system clock (OSCH)
//                       rst_n - synchronous active-low reset
//                       bus   - slave side of lauflicht_ctrl_if
//                               (en, mode, speed in; led, pos, tick out)
//  Revision    : 1.0 - initial release
// ============================================================================
module lauflicht_ctrl #(
    parameter  int N_LED      = 8,
    parameter  int PRESCALE   = 520000,
    parameter  int ACTIVE_LOW = 1,
    localparam int POS_W      = (N_LED > 1) ? $clog2(N_LED) : 1
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    lauflicht_ctrl_if.slave  bus
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [POS_W-1:0] c_pos_last = POS_W'(N_LED - 1);
    localparam logic [N_LED-1:0] c_pol      = (ACTIVE_LOW != 0) ? {N_LED{1'b1}} : {N_LED{1'b0}};

    // Terminal counts per speed setting; PRESCALE >= 8 keeps all of them >= 0
    localparam logic [CNT_W-1:0] c_term0 = CNT_W'((PRESCALE >> 0) - 1);
    localparam logic [CNT_W-1:0] c_term1 = CNT_W'((PRESCALE >> 1) - 1);
    localparam logic [CNT_W-1:0] c_term2 = CNT_W'((PRESCALE >> 2) - 1);
    localparam logic [CNT_W-1:0] c_term3 = CNT_W'((PRESCALE >> 3) - 1);

    typedef enum logic [0:0] {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [CNT_W-1:0] r_cnt_q,  w_cnt_d;
    logic [POS_W-1:0] r_pos_q,  w_pos_d;
    logic [N_LED-1:0] r_led_q,  w_led_d;
    dir_t             r_dir_q,  w_dir_d;
    logic             r_tick_q, w_tick_d;
    logic [CNT_W-1:0] w_term;
    logic             w_step;

    // One-hot of a position with board polarity applied
    function automatic logic [N_LED-1:0] f_led(input logic [POS_W-1:0] p);
        logic [N_LED-1:0] v;
        v = '0;
        for (int i = 0; i < N_LED; i++) begin
            v[i] = (p == POS_W'(i));
        end
        return v ^ c_pol;
    endfunction

    always_comb begin
        unique case (bus.speed)
            2'd0:    w_term = c_term0;
            2'd1:    w_term = c_term1;
            2'd2:    w_term = c_term2;
            default: w_term = c_term3;
        endcase
    end

    always_comb begin
        w_cnt_d  = r_cnt_q;
        w_pos_d  = r_pos_q;
        w_dir_d  = r_dir_q;
        w_step   = 1'b0;

        // ">=" so that a speed increase past the current count steps at once
        if (!bus.en) begin
            w_cnt_d = '0;
        end else if (r_cnt_q >= w_term) begin
            w_cnt_d = '0;
            w_step  = 1'b1;
        end else begin
            w_cnt_d = r_cnt_q + CNT_W'(1);
        end

        if (w_step) begin
            unique case (bus.mode)
                2'b00: begin
                    w_pos_d = (r_pos_q == c_pos_last) ? '0 : r_pos_q + POS_W'(1);
                    w_dir_d = DIR_UP;
                end
                2'b01: begin
                    w_pos_d = (r_pos_q == '0) ? c_pos_last : r_pos_q - POS_W'(1);
                    w_dir_d = DIR_DOWN;
                end
                2'b10: begin
                    // Turn around on an endpoint so each endpoint is lit once per bounce
                    if (r_dir_q == DIR_UP && r_pos_q == c_pos_last) begin
                        w_dir_d = DIR_DOWN;
                        w_pos_d = r_pos_q - POS_W'(1);
                    end else if (r_dir_q == DIR_DOWN && r_pos_q == '0) begin
                        w_dir_d = DIR_UP;
                        w_pos_d = POS_W'(1);
                    end else if (r_dir_q == DIR_UP) begin
                        w_pos_d = r_pos_q + POS_W'(1);
                    end else begin
                        w_pos_d = r_pos_q - POS_W'(1);
                    end
                end
                default: begin
                    w_pos_d = r_pos_q;
                end
            endcase
            // A single LED has nowhere to move
            if (N_LED == 1) begin
                w_pos_d = '0;
            end
        end

        w_tick_d = w_step;
        w_led_d  = f_led(w_pos_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt_q  <= '0;
            r_pos_q  <= '0;
            r_dir_q  <= DIR_UP;
            r_tick_q <= 1'b0;
            r_led_q  <= f_led('0);
        end else begin
            r_cnt_q  <= w_cnt_d;
            r_pos_q  <= w_pos_d;
            r_dir_q  <= w_dir_d;
            r_tick_q <= w_tick_d;
            r_led_q  <= w_led_d;
        end
    end

    assign bus.led  = r_led_q;
    assign bus.pos  = r_pos_q;
    assign bus.tick = r_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_lauflicht_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lauflicht_ctrl
//  Description : Self-checking bench for lauflicht_ctrl (N_LED=4, PRESCALE=8,
//                active-low LEDs). Directed sequences with literal
//                expectations, then randomized controls against a
//                behavioural model compared every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lauflicht_ctrl;

    localparam int N   = 4;
    localparam int PRE = 8;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    logic chk_on;

    lauflicht_ctrl_if #(.N_LED(N)) bus ();

    lauflicht_ctrl #(
        .N_LED      (N),
        .PRESCALE   (PRE),
        .ACTIVE_LOW (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_cnt;      // cycles elapsed in the current step period
    int m_pos;
    int m_up;       // 1 = moving up
    int m_tick;

    function automatic int exp_led(input int p);
        return (~(1 << p)) & ((1 << N) - 1);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_cnt = 0; m_pos = 0; m_up = 1; m_tick = 0;
        end else if (!bus.en) begin
            m_cnt = 0; m_tick = 0;
        end else if (m_cnt + 1 >= (PRE >> bus.speed)) begin
            m_cnt  = 0;
            m_tick = 1;
            case (bus.mode)
                2'd0: begin m_pos = (m_pos + 1) % N;     m_up = 1; end
                2'd1: begin m_pos = (m_pos + N - 1) % N; m_up = 0; end
                2'd2: begin
                    if (m_up == 1 && m_pos == N - 1) m_up = 0;
                    else if (m_up == 0 && m_pos == 0) m_up = 1;
                    m_pos = m_pos + (m_up == 1 ? 1 : -1);
                end
                default: ;
            endcase
        end else begin
            m_cnt  = m_cnt + 1;
            m_tick = 0;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_pos",  int'(bus.pos),  m_pos);
            chk("model_led",  int'(bus.led),  exp_led(m_pos));
            chk("model_tick", int'(bus.tick), m_tick);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic cyc(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic wait_tick(input string nm, input int exp_gap, input int exp_pos);
        int n;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!bus.tick && n < 64);
        chk({nm, "_gap"}, n, exp_gap);
        chk({nm, "_pos"}, int'(bus.pos), exp_pos);
        chk({nm, "_led"}, int'(bus.led), exp_led(exp_pos));
    endtask

    task automatic do_reset(input int k);
        rst_n = 1'b0;
        cyc(k);
        rst_n = 1'b1;
    endtask

    initial begin
        n_vec = 0; n_err = 0; chk_on = 1'b0;
        rst_n = 1'b0; bus.en = 1'b0; bus.mode = 2'd0; bus.speed = 2'd0;
        cyc(2);
        chk_on = 1'b1;

        // 1: reset state then left running
        chk("rst_pos", int'(bus.pos), 0);
        chk("rst_led", int'(bus.led), 4'b1110);
        chk("rst_tick", int'(bus.tick), 0);
        bus.en = 1'b1;
        rst_n  = 1'b1;
        wait_tick("left1", 8, 1);
        chk("left1_led_lit", int'(bus.led), 4'b1101);
        wait_tick("left2", 8, 2);
        wait_tick("left3", 8, 3);
        chk("left3_led_lit", int'(bus.led), 4'b0111);
        wait_tick("left4", 8, 0);

        // 2: right from pos 0
        bus.mode = 2'd1;
        wait_tick("right1", 8, 3);
        wait_tick("right2", 8, 2);
        wait_tick("right3", 8, 1);
        wait_tick("right4", 8, 0);
        wait_tick("right5", 8, 3);

        // 3: ping-pong from reset
        bus.mode = 2'd2;
        do_reset(1);
        wait_tick("pp1", 8, 1);
        wait_tick("pp2", 8, 2);
        wait_tick("pp3", 8, 3);
        wait_tick("pp4", 8, 2);
        wait_tick("pp5", 8, 1);
        wait_tick("pp6", 8, 0);
        wait_tick("pp7", 8, 1);
        wait_tick("pp8", 8, 2);

        // 4a: fastest speed ticks every cycle
        bus.mode  = 2'd0;
        bus.speed = 2'd3;
        do_reset(1);
        wait_tick("fast1", 1, 1);
        wait_tick("fast2", 1, 2);
        wait_tick("fast3", 1, 3);

        // 4b: speed raised while count already beyond the new terminal
        bus.speed = 2'd0;
        do_reset(1);
        cyc(5);
        chk("pre_speed_pos", int'(bus.pos), 0);
        bus.speed = 2'd2;
        wait_tick("spd1", 1, 1);
        wait_tick("spd2", 2, 2);
        wait_tick("spd3", 2, 3);

        // 5: freeze and re-enable, then hold
        bus.speed = 2'd0;
        do_reset(1);
        cyc(5);
        bus.en = 1'b0;
        cyc(20);
        chk("frozen_pos", int'(bus.pos), 0);
        bus.en = 1'b1;
        wait_tick("reen", 8, 1);
        bus.mode = 2'd3;
        wait_tick("hold1", 8, 1);
        wait_tick("hold2", 8, 1);

        // 6: reset mid ping-pong while descending
        bus.mode = 2'd2;
        do_reset(1);
        wait_tick("pr1", 8, 1);
        wait_tick("pr2", 8, 2);
        wait_tick("pr3", 8, 3);
        wait_tick("pr4", 8, 2);
        rst_n = 1'b0;
        cyc(1);
        chk("midrst_pos",  int'(bus.pos),  0);
        chk("midrst_led",  int'(bus.led),  4'b1110);
        chk("midrst_tick", int'(bus.tick), 0);
        rst_n = 1'b1;
        wait_tick("after_rst", 8, 1);

        // randomized controls, model checked every cycle
        for (int i = 0; i < 4000; i++) begin
            rst_n  = ($urandom_range(0, 199) != 0);
            bus.en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) bus.mode  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) bus.speed = 2'($urandom_range(0, 3));
            cyc(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
